// File: rtl/execute_norm_if.sv
// Operand/result handshake bundle for execute_norm.
// The master side drives operands and consumes results. The slave side is the normaliser.
interface execute_norm_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_value;
   logic [5:0]  out_count;
   logic        out_zero;

   modport master (
      output in_valid,
      output in_value,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_value,
      input  out_count,
      input  out_zero
   );

   modport slave (
      input  in_valid,
      input  in_value,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_value,
      output out_count,
      output out_zero
   );
endinterface

// File: rtl/execute_norm.sv
// Multi-cycle leading-zero normaliser: shifts an accepted operand left in 8/4/1-bit
// steps until bit 31 is set, and reports the shift distance and a zero flag.
module execute_norm (
   input  logic          clk,
   input  logic          reset,
   execute_norm_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] value_r;
   logic [5:0]  count_r;
   logic        zero_r;
   logic        in_ready_s;
   logic        out_valid_s;
   logic        step_done_s;

   // SHIFT is finished once the value is zero or already normalised
   always_comb begin
      step_done_s = 1'b0;
      if ((value_r == 32'd0) || value_r[31]) begin
         step_done_s = 1'b1;
      end else begin
         step_done_s = 1'b0;
      end
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (step_done_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // handshake decode, driven from the state register only
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready_s  = 1'b1;
            out_valid_s = 1'b0;
         end
         SHIFT: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
         DONE: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b1;
         end
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // operand capture and coarse-to-fine shift steps; the result holds in DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_r <= 32'd0;
         count_r <= 6'd0;
         zero_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  value_r <= bus.in_value;
                  count_r <= 6'd0;
                  zero_r  <= 1'b0;
               end
            end
            SHIFT: begin
               if (value_r == 32'd0) begin
                  count_r <= 6'd32;
                  zero_r  <= 1'b1;
               end else if (value_r[31]) begin
                  value_r <= value_r;
               end else if (value_r[31:24] == 8'd0) begin
                  value_r <= {value_r[23:0], 8'd0};
                  count_r <= count_r + 6'd8;
               end else if (value_r[31:28] == 4'd0) begin
                  value_r <= {value_r[27:0], 4'd0};
                  count_r <= count_r + 6'd4;
               end else begin
                  value_r <= {value_r[30:0], 1'b0};
                  count_r <= count_r + 6'd1;
               end
            end
            default: begin
               value_r <= value_r;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_value = value_r;
   assign bus.out_count = count_r;
   assign bus.out_zero  = zero_r;

endmodule

// File: doc/execute_norm.md
EXECUTE_NORM -- requirements
Module: execute_norm

Interface
Parameters: none.
REQ-001 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low SHALL force reset state immediately, independent of clk.
REQ-003 in_valid  input  1  upstream operand valid.
REQ-004 in_ready  output  1  block can accept an operand.
REQ-005 in_value  input  32  operand to normalise.
REQ-006 out_valid  output  1  result valid.
REQ-007 out_ready  input  1  downstream accepts the result.
REQ-008 out_value  output  32  normalised value: operand shifted left until bit 31 is set, or 0 for a zero operand.
REQ-009 out_count  output  6  leading-zero count of the operand, 0..32.
REQ-010 out_zero  output  1  operand was zero.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-013 In IDLE, in_valid=1 SHALL accept the operand at that edge: working register <= in_value, count <= 0, state <= SHIFT.
REQ-014 In SHIFT, the first matching rule SHALL apply each cycle: value==0 -> count <= 32, zero <= 1, DONE; value[31]==1 -> DONE; value[31:24]==0 -> shift left 8, count += 8; value[31:28]==0 -> shift left 4, count += 4; else shift left 1, count += 1.
REQ-015 Each shift SHALL fill vacated LSBs with zero; count SHALL never exceed 31 for a non-zero operand and SHALL use 6-bit arithmetic without wrap.
REQ-016 Latency: out_valid SHALL assert N+1 cycles after the acceptance edge, where N is the number of shift steps from REQ-014; a zero operand or an operand with bit 31 set SHALL take 1 cycle.
REQ-017 In DONE, out_value, out_count and out_zero SHALL hold stable while out_ready=0.
REQ-018 In DONE, out_ready=1 SHALL complete the transfer at that edge and return to IDLE; a new operand SHALL NOT be accepted in the same cycle.
REQ-019 in_valid SHALL be ignored in SHIFT and DONE, and in_value SHALL be sampled only at acceptance.
REQ-020 For every operand, out_count SHALL equal the combinational leading-zero count of the operand, and out_value SHALL equal the operand << out_count (0 for count 32).
REQ-021 out_zero SHALL be 1 if and only if out_count==32.

Reset
REQ-022 While reset=0: state=IDLE, in_ready=1 (after reset), out_valid=0, out_value=0, out_count=0, out_zero=0.
REQ-023 Reset asserted in SHIFT or DONE SHALL abort the operation and discard its result; no stale out_valid SHALL appear after release.
REQ-024 The first edge after reset release SHALL be able to accept an operand.

Verification
REQ-025 in_value=0x00000000 accepted -> out_valid 1 cycle later, out_value=0, out_count=32, out_zero=1.
REQ-026 in_value=0x7eefbeef -> N=1, out_valid 2 cycles after accept, out_value=0xfddf7dde, out_count=1, out_zero=0.
REQ-027 in_value=0x000001e0 -> steps 8,8,4,1,1,1 (N=6), out_valid 7 cycles after accept, out_value=0xf0000000, out_count=23; 0x00000001 -> N=7, out_value=0x80000000, out_count=31.
REQ-028 in_value=0x80000000 with out_ready held 0 for 5 cycles -> out_valid and outputs stable for those cycles, in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-029 Accept 0x00002000, assert reset=0 asynchronously mid-SHIFT -> outputs clear immediately; after release out_valid stays 0 until a new operand 0xdeadbeef completes with out_count=0.
REQ-030 Random sweep of 10k operands with random in_valid/out_ready stalls -> every result matches REQ-020 and no operand is lost or duplicated.
